mem_reg_pipe: RTL and testbench



---
 rtl/mem_reg_pipe.sv | 106 ++++++++++
 tb/tb_mem_reg_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_reg_pipe.sv
// mem_reg_pipe: elastic chain of DEPTH valid/ready register stages.
// Each stage collapses bubbles, because an empty stage always accepts.
// A synchronous flush drops every held word, and an occupancy counter
// tracks how many stages hold a valid word.
module mem_reg_pipe #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] DataIn,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] DataOut,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic [CW-1:0]    count
);

    // Per-stage state. Index 0 is the input side; DEPTH-1 is the output side.
    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [CW-1:0]    r_count;

    // Stage ready chain. w_ready[DEPTH] is the downstream ready.
    logic [DEPTH:0]   w_ready;
    logic [DEPTH-1:0] w_src_valid;
    logic [WIDTH-1:0] w_src_data [DEPTH];
    logic             w_accept_in;
    logic             w_accept_out;

    // Ready ripples from the output stage back toward the input stage.
    // An empty stage is always ready, which is what collapses bubbles.
    always_comb begin
        logic w_rdy;
        w_rdy            = out_ready;
        w_ready          = '0;
        w_ready[DEPTH]   = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_rdy      = ~r_valid[i] | w_rdy;
            w_ready[i] = w_rdy;
        end
    end

    // Each stage is fed by the stage before it; stage 0 is fed by the upstream port.
    always_comb begin
        w_src_valid[0] = in_valid;
        w_src_data[0]  = DataIn;
        for (int i = 1; i < DEPTH; i++) begin
            w_src_valid[i] = r_valid[i-1];
            w_src_data[i]  = r_data[i-1];
        end
    end

    // Handshake events on both ends. Flush blocks new words, but the
    // output word shown in a flush cycle may still be taken downstream.
    always_comb begin
        in_ready     = w_ready[0] & ~flush;
        w_accept_in  = in_valid & in_ready;
        w_accept_out = r_valid[DEPTH-1] & out_ready;
    end

    // Stage registers. Reset clears everything; flush clears only the valid bits.
    // Data is loaded only when a valid word moves in, so an empty stage keeps its last word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_ready[i]) begin
                    r_valid[i] <= w_src_valid[i];
                    if (w_src_valid[i]) begin
                        r_data[i] <= w_src_data[i];
                    end
                end
            end
        end
    end

    // Occupancy counter. It moves by the handshakes, so it always equals
    // the number of valid stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(w_accept_in) - CW'(w_accept_out);
        end
    end

    // Output stage drives the downstream port directly from registers.
    always_comb begin
        out_valid = r_valid[DEPTH-1];
        DataOut   = r_data[DEPTH-1];
        count     = r_count;
    end

endmodule

// File: tb/tb_mem_reg_pipe.sv
// Directed self-checking bench for mem_reg_pipe with WIDTH=32 and DEPTH=3.
module tb_mem_reg_pipe;

    localparam int WIDTH = 32;
    localparam int DEPTH = 3;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] DataIn;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] DataOut;
    logic             out_valid;
    logic             out_ready;
    logic             flush;
    logic [CW-1:0]    count;

    int checks;
    int errors;

    mem_reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .DataIn    (DataIn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .DataOut   (DataOut),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        DataIn    = 32'd64;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Reset with a word offered: nothing may be stored.
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data", DataOut, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("rst_after_count", 32'(count), 32'd0);
        chk("rst_after_valid", 32'(out_valid), 32'd0);

        // Streaming 64,128,256 with out_ready=1.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        DataIn    = 32'd64;
        #1;
        chk("stream_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("stream_cnt1", 32'(count), 32'd1);
        DataIn = 32'd128;
        tick();
        chk("stream_lat_valid", 32'(out_valid), 32'd0);
        DataIn = 32'd256;
        tick();
        in_valid = 1'b0;
        chk("stream_valid", 32'(out_valid), 32'd1);
        chk("stream_d0", DataOut, 32'd64);
        chk("stream_peak", 32'(count), 32'd3);
        tick();
        chk("stream_d1", DataOut, 32'd128);
        chk("stream_v1", 32'(out_valid), 32'd1);
        tick();
        chk("stream_d2", DataOut, 32'd256);
        chk("stream_v2", 32'(out_valid), 32'd1);
        tick();
        chk("stream_empty", 32'(out_valid), 32'd0);
        chk("stream_hold", DataOut, 32'd256);
        chk("stream_cnt0", 32'(count), 32'd0);

        // Stall fill: 1,2,3 accepted, 4 held back.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            DataIn = 32'(k);
            #1;
            chk("fill_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        DataIn = 32'd4;
        #1;
        chk("fill_count", 32'(count), 32'd3);
        chk("fill_full_ready", 32'(in_ready), 32'd0);
        chk("fill_head", DataOut, 32'd1);
        tick();
        chk("fill_hold_count", 32'(count), 32'd3);
        chk("fill_hold_head", DataOut, 32'd1);
        out_ready = 1'b1;
        #1;
        chk("fill_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            chk("fill_order_valid", 32'(out_valid), 32'd1);
            chk("fill_order_data", DataOut, 32'(k));
            tick();
        end
        chk("fill_drained", 32'(out_valid), 32'd0);
        chk("fill_drained_cnt", 32'(count), 32'd0);

        // Bubble collapse: 10, idle, 20, with out_ready=0.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        DataIn    = 32'd10;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        DataIn   = 32'd20;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("bubble_count", 32'(count), 32'd2);
        chk("bubble_head", DataOut, 32'd10);
        chk("bubble_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("bubble_second_valid", 32'(out_valid), 32'd1);
        chk("bubble_second", DataOut, 32'd20);
        tick();
        chk("bubble_empty", 32'(out_valid), 32'd0);
        chk("bubble_cnt0", 32'(count), 32'd0);

        // Flush a full pipe holding 5,6,7.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 5; k <= 7; k++) begin
            DataIn = 32'(k);
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        #1;
        chk("flush_pre_count", 32'(count), 32'd3);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        chk("flush_shows_valid", 32'(out_valid), 32'd1);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        chk("flush_data_kept", DataOut, 32'd5);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        DataIn    = 32'd9;
        tick();
        in_valid = 1'b0;
        tick();
        chk("flush_lat_valid", 32'(out_valid), 32'd0);
        tick();
        chk("flush_word_valid", 32'(out_valid), 32'd1);
        chk("flush_word", DataOut, 32'd9);
        chk("flush_word_cnt", 32'(count), 32'd1);
        tick();
        chk("flush_alone", 32'(out_valid), 32'd0);

        // Full pipe with simultaneous accept and drain for 10 cycles.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 100; k <= 102; k++) begin
            DataIn = 32'(k);
            tick();
        end
        chk("sim_fill_cnt", 32'(count), 32'd3);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            DataIn = 32'(103 + k);
            #1;
            chk("sim_in_ready", 32'(in_ready), 32'd1);
            tick();
            chk("sim_count", 32'(count), 32'd3);
            chk("sim_data", DataOut, 32'(101 + k));
        end
        in_valid = 1'b0;
        tick();
        chk("sim_drain1", DataOut, 32'd111);
        chk("sim_drain1_cnt", 32'(count), 32'd2);
        tick();
        chk("sim_drain2", DataOut, 32'd112);
        tick();
        chk("sim_drain_empty", 32'(out_valid), 32'd0);
        chk("sim_drain_cnt", 32'(count), 32'd0);

        // Reset mid-stream clears valid, data and count.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 40; k <= 42; k++) begin
            DataIn = 32'(k);
            tick();
        end
        rst   = 1'b1;
        flush = 1'b1;
        tick();
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_data", DataOut, 32'd0);
        chk("midrst_count", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
